// File: rtl/delay_hyst_multi_pkg.sv
// Shared definitions for the multi-channel hysteresis delay: state encoding
// and the counter-width helper.
package delay_hyst_multi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RISE_WAIT = 2'd1,
    ST_ON        = 2'd2,
    ST_FALL_WAIT = 2'd3
  } state_e;

  // Counter must hold the larger terminal count; never narrower than one bit.
  function automatic int cnt_width(input int on_bits, input int off_bits);
    int w;
    w = (on_bits > off_bits) ? on_bits : off_bits;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/delay_hyst_ch.sv
// Single channel: asserts after 2**ON_BITS consecutive high samples and
// deasserts after 2**OFF_BITS consecutive low samples, with edge pulses.
module delay_hyst_ch
  import delay_hyst_multi_pkg::*;
#(
  parameter int ON_BITS  = 4,
  parameter int OFF_BITS = 0
) (
  input  logic CLK,
  input  logic RESET_N,
  input  logic clr,
  input  logic in,
  output logic out,
  output logic rise,
  output logic fall
);

  localparam int CW = cnt_width(ON_BITS, OFF_BITS);
  localparam logic [CW-1:0] ON_LAST  = CW'((1 << ON_BITS) - 1);
  localparam logic [CW-1:0] OFF_LAST = CW'((1 << OFF_BITS) - 1);
  localparam bit ON_ONE  = (ON_BITS == 0);
  localparam bit OFF_ONE = (OFF_BITS == 0);

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          out_q;
  logic          rise_q;
  logic          fall_q;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      out_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      if (clr) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
        out_q   <= 1'b0;
        fall_q  <= out_q;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (in) begin
              if (ON_ONE) begin
                state_q <= ST_ON;
                out_q   <= 1'b1;
                rise_q  <= 1'b1;
              end else begin
                state_q <= ST_RISE_WAIT;
                cnt_q   <= CW'(1);
              end
            end
          end
          ST_RISE_WAIT: begin
            if (!in) begin
              state_q <= ST_IDLE;
              cnt_q   <= '0;
            end else if (cnt_q == ON_LAST) begin
              state_q <= ST_ON;
              cnt_q   <= '0;
              out_q   <= 1'b1;
              rise_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          ST_ON: begin
            if (!in) begin
              if (OFF_ONE) begin
                state_q <= ST_IDLE;
                out_q   <= 1'b0;
                fall_q  <= 1'b1;
              end else begin
                state_q <= ST_FALL_WAIT;
                cnt_q   <= CW'(1);
              end
            end
          end
          ST_FALL_WAIT: begin
            if (in) begin
              state_q <= ST_ON;
              cnt_q   <= '0;
            end else if (cnt_q == OFF_LAST) begin
              state_q <= ST_IDLE;
              cnt_q   <= '0;
              out_q   <= 1'b0;
              fall_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          default: begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            out_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign out  = out_q;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/delay_hyst_multi.sv
// NCH independent hysteresis-delay channels with any/all aggregates taken
// directly from the registered channel outputs.
module delay_hyst_multi
  import delay_hyst_multi_pkg::*;
#(
  parameter int NCH      = 4,
  parameter int ON_BITS  = 4,
  parameter int OFF_BITS = 0
) (
  input  logic           CLK,
  input  logic           RESET_N,
  input  logic           clr,
  input  logic [NCH-1:0] in,
  output logic [NCH-1:0] out,
  output logic [NCH-1:0] rise,
  output logic [NCH-1:0] fall,
  output logic           any_out,
  output logic           all_out
);

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    delay_hyst_ch #(
      .ON_BITS (ON_BITS),
      .OFF_BITS(OFF_BITS)
    ) u_ch (
      .CLK    (CLK),
      .RESET_N(RESET_N),
      .clr    (clr),
      .in     (in[g]),
      .out    (out[g]),
      .rise   (rise[g]),
      .fall   (fall[g])
    );
  end

  assign any_out = |out;
  assign all_out = &out;

endmodule
